kernel_shift_bank: RTL
======================

KERNEL_SHIFT_BANK -- requirements
Module: kernel_shift_bank

Interface
REQ-001 The module SHALL have parameter IO_DATA_WIDTH, default 16, meaning the bit width of one data word.
REQ-002 The module SHALL have parameter NB_GROUPS, default 12, meaning the number of independently selectable lane groups.
REQ-003 The module SHALL have parameter KERNEL_SIZE, default 3, meaning the number of lanes per group and the number of input words per cycle.
REQ-004 The module SHALL have parameter LOG2_OF_DEPTH, default 3, meaning log2 of the per-lane delay depth D (D = 2**LOG2_OF_DEPTH, legal D >= 2).
REQ-005 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-006 Port rst_in  input  1  is the reset, synchronous and active-high.
REQ-007 Port din  input  KERNEL_SIZE*IO_DATA_WIDTH  carries the input words; lane k occupies bits [k*IO_DATA_WIDTH +: IO_DATA_WIDTH].
REQ-008 Port in_valid  input  1  indicates that din holds a valid word set.
REQ-009 Port in_ready  output  1  indicates that din is consumed this cycle.
REQ-010 Port load_select  input  NB_GROUPS  selects, per group, load from din (1) or recirculation (0).
REQ-011 Port cycle_enable  input  1  requests one advance of all groups.
REQ-012 Port flush  input  1  clears all valid tags and the rotation counter.
REQ-013 Port out  output  NB_GROUPS*KERNEL_SIZE*IO_DATA_WIDTH  exposes the tail stage of each lane; lane (g*KERNEL_SIZE+k) occupies slot g*KERNEL_SIZE+k.
REQ-014 Port out_valid  output  NB_GROUPS  asserts a valid tag on each group's tail stage.
REQ-015 Port window_done  output  1  is a one-cycle pulse on rotation-counter wrap.

Function
REQ-016 Each lane SHALL be a D-stage shift register (stage 0 = head, stage D-1 = tail), and each group SHALL hold one valid tag per stage.
REQ-017 Rule for advance: advance = cycle_enable AND NOT flush AND (in_valid OR load_select == 0).
REQ-018 On advance, stage 0 of group g SHALL take din if load_select[g] is 1, else its own tail; stages 1..D-1 SHALL take the previous stage; tags SHALL move identically (stage-0 tag = 1 on load, = tail tag on recirculate).
REQ-019 Without advance, all stages and tags SHALL hold.
REQ-020 in_ready SHALL equal advance AND (load_select != 0), combinationally.
REQ-021 A word loaded on advance n SHALL appear on out after advance n+D-1, i.e. D advances total latency; a recirculated word SHALL return to the tail every D advances.
REQ-022 out and out_valid SHALL be driven combinationally from the tail stage (no extra register).
REQ-023 A rotation counter of LOG2_OF_DEPTH bits SHALL increment on each advance and wrap from D-1 to 0; window_done SHALL be registered and assert for exactly one cycle following the advance that wraps it.
REQ-024 Flush SHALL have priority over cycle_enable: no advance, all tags cleared, counter cleared, window_done low next cycle, data stages unchanged.
REQ-025 If load_select changes between advances, each advance SHALL use the value sampled at that edge; groups SHALL never interfere with each other.
REQ-026 If in_valid is low while any load_select bit is set, all groups SHALL stall (including recirculating groups), preserving group alignment.

Reset
REQ-027 While rst_in is high at a rising edge, all data stages SHALL clear to 0, all tags to 0, the counter to 0 and window_done to 0; rst_in SHALL override flush and advance.
REQ-028 After reset, out SHALL read 0, out_valid 0, window_done 0, and in_ready SHALL follow REQ-020.

Configuration
REQ-029 Macro KSB_ZERO_INVALID_EN: when defined, each out slot SHALL read 0 whenever its group's tail tag is 0; when undefined, out SHALL show raw stored tail data regardless of tag.

Verification
REQ-030 Reset, then load_select=12'h001, in_valid=1, cycle_enable=1, din lanes={3,2,1} for 8 cycles -> out slots 0..2 = {1,2,3} and out_valid[0]=1 exactly after the 8th advance; the other groups are out_valid=0.
REQ-031 After REQ-030, load_select=0 for 16 advances -> group 0 tail repeats the same 8-word sequence twice; window_done pulses after advances 8 and 16 only.
REQ-032 load_select=12'hFFF, cycle_enable=1, in_valid toggling 1/0 -> advance and in_ready only on in_valid=1 cycles; the counter increments every second cycle.
REQ-033 Groups filled, then flush=1 together with cycle_enable=1 -> no shift, out_valid=0 next cycle, data retained (visible when macro undefined, 0 when KSB_ZERO_INVALID_EN defined).
REQ-034 rst_in asserted mid-stream with D=4 and NB_GROUPS=2 parameter override -> all outputs 0 next cycle; reloading yields correct 4-advance latency.

Source files
------------

// File: rtl/kernel_shift_bank.sv
// Bank of per-lane D-stage shift registers with grouped load/recirculate control,
// per-stage valid tags and a rotation counter. Optional macro: KSB_ZERO_INVALID_EN.
module kernel_shift_bank #(
  parameter int IO_DATA_WIDTH = 16,
  parameter int NB_GROUPS     = 12,
  parameter int KERNEL_SIZE   = 3,
  parameter int LOG2_OF_DEPTH = 3
) (
  input  logic                                        clk,
  input  logic                                        rst_in,
  input  logic [KERNEL_SIZE*IO_DATA_WIDTH-1:0]        din,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [NB_GROUPS-1:0]                        load_select,
  input  logic                                        cycle_enable,
  input  logic                                        flush,
  output logic [NB_GROUPS*KERNEL_SIZE*IO_DATA_WIDTH-1:0] out,
  output logic [NB_GROUPS-1:0]                        out_valid,
  output logic                                        window_done
);

  localparam int DEPTH = 1 << LOG2_OF_DEPTH;
  localparam int LANES = NB_GROUPS * KERNEL_SIZE;
  localparam logic [LOG2_OF_DEPTH-1:0] CNT_LAST = '1;

  logic [IO_DATA_WIDTH-1:0] stage_q [LANES][DEPTH];
  logic [DEPTH-1:0]         tag_q   [NB_GROUPS];
  logic [LOG2_OF_DEPTH-1:0] rot_cnt_q;
  logic                     window_done_q;
  logic                     any_load;
  logic                     advance;

  // A stalled load stalls every group so recirculating groups stay aligned.
  assign any_load = (load_select != '0);
  assign advance  = cycle_enable && !flush && (in_valid || !any_load);
  assign in_ready = advance && any_load;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int l = 0; l < LANES; l++) begin
        for (int s = 0; s < DEPTH; s++) begin
          stage_q[l][s] <= '0;
        end
      end
      for (int g = 0; g < NB_GROUPS; g++) begin
        tag_q[g] <= '0;
      end
      rot_cnt_q     <= '0;
      window_done_q <= 1'b0;
    end else if (flush) begin
      for (int g = 0; g < NB_GROUPS; g++) begin
        tag_q[g] <= '0;
      end
      rot_cnt_q     <= '0;
      window_done_q <= 1'b0;
    end else begin
      window_done_q <= advance && (rot_cnt_q == CNT_LAST);
      if (advance) begin
        rot_cnt_q <= rot_cnt_q + 1'b1;
        for (int g = 0; g < NB_GROUPS; g++) begin
          // bit 0 is the head stage, bit DEPTH-1 the tail
          tag_q[g] <= {tag_q[g][DEPTH-2:0], load_select[g] ? 1'b1 : tag_q[g][DEPTH-1]};
          for (int k = 0; k < KERNEL_SIZE; k++) begin
            for (int s = DEPTH - 1; s > 0; s--) begin
              stage_q[g*KERNEL_SIZE+k][s] <= stage_q[g*KERNEL_SIZE+k][s-1];
            end
            stage_q[g*KERNEL_SIZE+k][0] <= load_select[g]
                ? din[k*IO_DATA_WIDTH +: IO_DATA_WIDTH]
                : stage_q[g*KERNEL_SIZE+k][DEPTH-1];
          end
        end
      end
    end
  end

  assign window_done = window_done_q;

  for (genvar g = 0; g < NB_GROUPS; g++) begin : g_group
    assign out_valid[g] = tag_q[g][DEPTH-1];
    for (genvar k = 0; k < KERNEL_SIZE; k++) begin : g_lane
`ifdef KSB_ZERO_INVALID_EN
      assign out[(g*KERNEL_SIZE+k)*IO_DATA_WIDTH +: IO_DATA_WIDTH] =
          tag_q[g][DEPTH-1] ? stage_q[g*KERNEL_SIZE+k][DEPTH-1] : '0;
`else
      assign out[(g*KERNEL_SIZE+k)*IO_DATA_WIDTH +: IO_DATA_WIDTH] =
          stage_q[g*KERNEL_SIZE+k][DEPTH-1];
`endif
    end
  end

endmodule
